// File: rtl/c1_zone_latch_pkg.sv
// c1_pkg: shared zone/state types and zone nibble constants for the C1 bus front-end.
package c1_pkg;
    typedef enum logic [2:0] {Z_NONE, Z_ROM, Z_WRAM, Z_PORT, Z_CARD, Z_SROM} zone_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_TIMEOUT} state_t;
    localparam logic [3:0] NIB_ROM     = 4'h0;
    localparam logic [3:0] NIB_WRAM    = 4'h1;
    localparam logic [3:0] NIB_PORT    = 4'h2;
    localparam logic [3:0] NIB_CARD_LO = 4'h8;
    localparam logic [3:0] NIB_CARD_HI = 4'hB;
    localparam logic [3:0] NIB_SROM    = 4'hC;
    // Active-low select vector, bit order {SROM, CARD, PORT, WRAM, ROM}
    function automatic logic [4:0] zone_n(zone_t z);
        return ~{z == Z_SROM, z == Z_CARD, z == Z_PORT, z == Z_WRAM, z == Z_ROM};
    endfunction
endpackage

// File: rtl/c1_zone_latch_if.sv
// c1_zone_latch_if: 68k-side bus signals and zone/timeout outputs of the C1 zone latch.
interface c1_zone_latch_if;
    logic        nAS;
    logic        M68K_RW;
    logic [23:1] M68K_ADDR;
    logic        SYSTEM_CDx;
    logic        nDTACK;
    logic        nROM_ZONE;
    logic        nWRAM_ZONE;
    logic        nPORT_ZONE;
    logic        nCARD_ZONE;
    logic        nSROM_ZONE;
    logic        CYCLE_RW;
    logic        nBERR;
    logic        BUS_TIMEOUT;
    modport master (
        output nAS, M68K_RW, M68K_ADDR, SYSTEM_CDx, nDTACK,
        input  nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE, CYCLE_RW, nBERR, BUS_TIMEOUT
    );
    modport slave (
        input  nAS, M68K_RW, M68K_ADDR, SYSTEM_CDx, nDTACK,
        output nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nCARD_ZONE, nSROM_ZONE, CYCLE_RW, nBERR, BUS_TIMEOUT
    );
endinterface

// File: rtl/c1_zone_latch_decode.sv
// c1_zone_decode: A23..A20 plus memory-map select to zone code and active-low one-hot selects.
module c1_zone_decode
    import c1_pkg::*;
(
    input  logic [3:0] addr_hi_i,
    input  logic       system_cd_i,
    output zone_t      zone_o,
    output logic [4:0] n_zone_o
);
    // On the CD map the bottom megabyte is work RAM instead of cart ROM
    assign zone_o = (addr_hi_i == NIB_ROM)  ? (system_cd_i ? Z_WRAM : Z_ROM) :
                    (addr_hi_i == NIB_WRAM) ? Z_WRAM :
                    (addr_hi_i == NIB_PORT) ? Z_PORT :
                    (addr_hi_i >= NIB_CARD_LO && addr_hi_i <= NIB_CARD_HI) ? Z_CARD :
                    (addr_hi_i == NIB_SROM) ? Z_SROM : Z_NONE;
    assign n_zone_o = zone_n(zone_o);
endmodule

// File: rtl/c1_zone_latch.sv
// c1_zone_latch: latches 68k zone selects per bus cycle and raises nBERR when nDTACK never arrives.
module c1_zone_latch
    import c1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic CLK_68KCLK,
    input  logic nRESET,
    c1_zone_latch_if.slave bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    zone_t            zone_q, zone_d;
    zone_t            live_zone;
    logic [4:0]       live_n;
    logic             rw_q, rw_d;
    logic             tout_q, tout_d;
    logic             unused_addr;
    assign unused_addr = ^bus.M68K_ADDR[19:1];
    c1_zone_decode u_decode (
        .addr_hi_i  (bus.M68K_ADDR[23:20]),
        .system_cd_i(bus.SYSTEM_CDx),
        .zone_o     (live_zone),
        .n_zone_o   (live_n)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zone_d  = zone_q;
        rw_d    = rw_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (!bus.nAS) begin
                state_d = ST_ACTIVE;
                cnt_d   = CNT_W'(1);
                zone_d  = live_zone;
                rw_d    = bus.M68K_RW;
            end
            ST_ACTIVE: if (bus.nAS) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                zone_d  = Z_NONE;
                rw_d    = 1'b1;
            end else if (bus.nDTACK) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                    tout_d  = 1'b1;
                end
            end
            ST_TIMEOUT: if (bus.nAS) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                zone_d  = Z_NONE;
                rw_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            zone_q  <= Z_NONE;
            rw_q    <= 1'b1;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zone_q  <= zone_d;
            rw_q    <= rw_d;
            tout_q  <= tout_d;
        end
    end
    // Idle passes the live decode through so the wait generator sees it before the first edge
    logic [4:0] zones_n;
    assign zones_n = (state_q != ST_IDLE) ? zone_n(zone_q) :
                     (bus.nAS || !nRESET) ? 5'h1F : live_n;
    assign {bus.nSROM_ZONE, bus.nCARD_ZONE, bus.nPORT_ZONE, bus.nWRAM_ZONE, bus.nROM_ZONE} = zones_n;
    assign bus.CYCLE_RW    = (state_q != ST_IDLE) ? rw_q : (bus.nAS || !nRESET || bus.M68K_RW);
    assign bus.nBERR       = state_q != ST_TIMEOUT;
    assign bus.BUS_TIMEOUT = tout_q;
endmodule

// File: tb/tb_c1_zone_latch.sv
// tb_c1_zone_latch: directed and random bus cycles checked against a cycle-level reference model.
module tb_c1_zone_latch;
    localparam int T = 64;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    c1_zone_latch_if bus();
    c1_zone_latch #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .CLK_68KCLK(clk),
        .nRESET    (nreset),
        .bus       (bus)
    );
    always #5 clk = ~clk;
    // Reference model: one bus cycle at a time
    logic       m_cyc = 1'b0;
    logic       m_tmo = 1'b0;
    logic       m_pulse = 1'b0;
    logic       m_rw = 1'b1;
    logic [4:0] m_z = 5'h1F;
    int         m_cnt = 0;
    function automatic logic [4:0] dec(input logic [3:0] n, input logic cd);
        logic [4:0] s;
        s = 5'b0;
        if (n == 4'h0) s[cd ? 1 : 0] = 1'b1;
        else if (n == 4'h1) s[1] = 1'b1;
        else if (n == 4'h2) s[2] = 1'b1;
        else if (n >= 4'h8 && n <= 4'hB) s[3] = 1'b1;
        else if (n == 4'hC) s[4] = 1'b1;
        return ~s;
    endfunction
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    task automatic compare();
        logic [4:0] ez;
        ez = m_cyc ? m_z : (bus.nAS ? 5'h1F : dec(bus.M68K_ADDR[23:20], bus.SYSTEM_CDx));
        check("zones", 8'({bus.nSROM_ZONE, bus.nCARD_ZONE, bus.nPORT_ZONE, bus.nWRAM_ZONE, bus.nROM_ZONE}), 8'(ez));
        check("cycle_rw", 8'(bus.CYCLE_RW), 8'(m_cyc ? m_rw : (bus.nAS | bus.M68K_RW)));
        check("nberr", 8'(bus.nBERR), 8'(!m_tmo));
        check("bus_timeout", 8'(bus.BUS_TIMEOUT), 8'(m_pulse));
    endtask
    task automatic model_edge();
        if (!m_cyc) begin
            m_pulse = 1'b0;
            if (!bus.nAS) begin
                m_cyc = 1'b1;
                m_z   = dec(bus.M68K_ADDR[23:20], bus.SYSTEM_CDx);
                m_rw  = bus.M68K_RW;
                m_cnt = 1;
                m_tmo = 1'b0;
            end
        end else if (bus.nAS) begin
            m_cyc = 1'b0;
            m_tmo = 1'b0;
            m_pulse = 1'b0;
        end else if (m_tmo || !bus.nDTACK) begin
            m_pulse = 1'b0;
        end else begin
            m_pulse = (m_cnt == T - 1);
            m_tmo = m_pulse;
            if (m_cnt < 127) m_cnt++;
        end
    endtask
    task automatic step(input logic nas, input logic dt, input logic [3:0] nib);
        @(negedge clk);
        bus.nAS = nas;
        bus.nDTACK = dt;
        bus.M68K_ADDR = {nib, 19'($urandom)};
        #1 compare();
        @(posedge clk);
        model_edge();
    endtask
    task automatic run_cycle(input logic [3:0] nib, input logic cd, input logic rw, input int len,
                             input int ack_at, input int chg_at, input logic [3:0] chg_nib, input int gap);
        bus.SYSTEM_CDx = cd;
        bus.M68K_RW = rw;
        for (int k = 1; k <= len; k++)
            step(1'b0, !(ack_at != 0 && k >= ack_at), (chg_at != 0 && k >= chg_at) ? chg_nib : nib);
        for (int g = 0; g < gap; g++)
            step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    endtask
    initial begin
        bus.nAS = 1'b1;
        bus.M68K_RW = 1'b1;
        bus.M68K_ADDR = '0;
        bus.SYSTEM_CDx = 1'b0;
        bus.nDTACK = 1'b1;
        @(negedge clk);
        #1 compare();
        nreset = 1'b1;
        // Mid-cycle reset with the counter at 20, then fresh decode of a new address
        bus.SYSTEM_CDx = 1'b0;
        bus.M68K_RW = 1'b0;
        for (int k = 1; k <= 20; k++) step(1'b0, 1'b1, 4'h8);
        @(negedge clk);
        #2 nreset = 1'b0;
        m_cyc = 1'b0; m_tmo = 1'b0; m_pulse = 1'b0; m_rw = 1'b1;
        #1;
        check("rst_zones", 8'({bus.nSROM_ZONE, bus.nCARD_ZONE, bus.nPORT_ZONE, bus.nWRAM_ZONE, bus.nROM_ZONE}), 8'h1F);
        check("rst_nberr", 8'(bus.nBERR), 8'h1);
        check("rst_rw", 8'(bus.CYCLE_RW), 8'h1);
        check("rst_pulse", 8'(bus.BUS_TIMEOUT), 8'h0);
        @(negedge clk);
        bus.M68K_ADDR = {4'h2, 19'h0};
        #1 check("rst_hold_zones", 8'({bus.nSROM_ZONE, bus.nCARD_ZONE, bus.nPORT_ZONE, bus.nWRAM_ZONE, bus.nROM_ZONE}), 8'h1F);
        nreset = 1'b1;
        #1 compare();
        @(posedge clk);
        model_edge();
        run_cycle(4'h2, 1'b0, 1'b0, 3, 2, 0, 4'h0, 2);
        // Cart read, CD-map read, unmapped, address change while active
        run_cycle(4'h0, 1'b0, 1'b1, 4, 3, 0, 4'h0, 2);
        run_cycle(4'h0, 1'b1, 1'b1, 4, 3, 0, 4'h0, 1);
        run_cycle(4'h3, 1'b0, 1'b0, 3, 2, 0, 4'h0, 1);
        run_cycle(4'h2, 1'b0, 1'b1, 5, 0, 2, 4'hC, 1);
        // Timeout, nAS rising on the threshold edge, ack on the threshold edge
        run_cycle(4'h8, 1'b0, 1'b1, 70, 0, 0, 4'h0, 2);
        run_cycle(4'h8, 1'b0, 1'b1, 63, 0, 0, 4'h0, 2);
        run_cycle(4'hA, 1'b0, 1'b0, 70, 64, 0, 4'h0, 2);
        run_cycle(4'hC, 1'b0, 1'b1, 64, 0, 0, 4'h0, 1);
        for (int c = 0; c < 80; c++) begin
            int len;
            len = $urandom_range(1, 80);
            run_cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), len,
                      ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, len + 2),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0,
                      4'($urandom_range(0, 15)), $urandom_range(1, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
